// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - direction codes, FSM state type and ball constants shared by the Pong referee
package pong_pkg;

  // Direction codes understood by the ball-movement block
  localparam logic [3:0] DIR_R_UP45   = 4'd1;
  localparam logic [3:0] DIR_R_UP30   = 4'd2;
  localparam logic [3:0] DIR_R_FRONT  = 4'd3;
  localparam logic [3:0] DIR_R_DOWN30 = 4'd4;
  localparam logic [3:0] DIR_R_DOWN45 = 4'd5;
  localparam logic [3:0] DIR_L_DOWN45 = 4'd6;
  localparam logic [3:0] DIR_L_DOWN30 = 4'd7;
  localparam logic [3:0] DIR_L_FRONT  = 4'd8;
  localparam logic [3:0] DIR_L_UP30   = 4'd9;
  localparam logic [3:0] DIR_L_UP45   = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_t;

  // Pixel step of the ball per move; also the miss margin at the field edges
  localparam int unsigned STEP = 5;

  // Where reset_to_start parks the ball
  localparam logic [10:0] BALL_START_X = 11'd400;
  localparam logic [10:0] BALL_START_Y = 11'd325;

  function automatic logic is_right(input logic [3:0] d);
    return (d >= DIR_R_UP45) && (d <= DIR_R_DOWN45);
  endfunction

  function automatic logic is_up(input logic [3:0] d);
    return (d == DIR_R_UP45) || (d == DIR_R_UP30) || (d == DIR_L_UP30) || (d == DIR_L_UP45);
  endfunction

  function automatic logic is_down(input logic [3:0] d);
    return (d == DIR_R_DOWN30) || (d == DIR_R_DOWN45) || (d == DIR_L_DOWN45) || (d == DIR_L_DOWN30);
  endfunction

  // Flip the vertical component; the mapping is its own inverse so it serves both walls
  function automatic logic [3:0] wall_mirror(input logic [3:0] d);
    case (d)
      DIR_R_UP45:   return DIR_R_DOWN45;
      DIR_R_DOWN45: return DIR_R_UP45;
      DIR_R_UP30:   return DIR_R_DOWN30;
      DIR_R_DOWN30: return DIR_R_UP30;
      DIR_L_UP30:   return DIR_L_DOWN30;
      DIR_L_DOWN30: return DIR_L_UP30;
      DIR_L_UP45:   return DIR_L_DOWN45;
      DIR_L_DOWN45: return DIR_L_UP45;
      default:      return d;
    endcase
  endfunction

  // Flip the horizontal component only: codes are laid out so that d and 11-d mirror
  function automatic logic [3:0] paddle_mirror(input logic [3:0] d);
    return 4'd11 - d;
  endfunction

  function automatic logic [3:0] serve_dir(input logic serve_right, input logic alt);
    if (serve_right) return alt ? DIR_R_DOWN30 : DIR_R_UP30;
    return alt ? DIR_L_DOWN30 : DIR_L_UP30;
  endfunction

endpackage

// File: rtl/pong_ball_referee_if.sv
// rtl/pong_ball_referee_if.sv - referee <-> ball datapath bundle (positions in, motion control out)
interface pong_ball_referee_if;

  logic [10:0] ball_position_horizontal;
  logic [10:0] ball_position_vertical;
  logic [10:0] paddle_left_vertical;
  logic [10:0] paddle_right_vertical;
  logic [3:0]  direction;
  logic        stand;
  logic        reset_to_start;

  // Referee side: reads positions, steers the ball
  modport master (
    input  ball_position_horizontal,
    input  ball_position_vertical,
    input  paddle_left_vertical,
    input  paddle_right_vertical,
    output direction,
    output stand,
    output reset_to_start
  );

  // Ball datapath side
  modport slave (
    output ball_position_horizontal,
    output ball_position_vertical,
    output paddle_left_vertical,
    output paddle_right_vertical,
    input  direction,
    input  stand,
    input  reset_to_start
  );

endinterface

// File: rtl/paddle_zone.sv
// rtl/paddle_zone.sv - vertical overlap and hit zone of the ball against one paddle (zone port only with PADDLE_ZONE_ANGLE_EN)
module paddle_zone #(
  parameter int unsigned BALL_SIZE = 10,
  parameter int unsigned PADDLE_H  = 80
) (
  input  logic [10:0] ball_v,
  input  logic [10:0] paddle_y,
`ifdef PADDLE_ZONE_ANGLE_EN
  output logic [2:0]  zone,
`endif
  output logic        overlap
);

  localparam logic [11:0] BS12 = 12'(BALL_SIZE);
  localparam logic [11:0] PH12 = 12'(PADDLE_H);

  logic [11:0] bv;
  logic [11:0] py;

  assign bv = {1'b0, ball_v};
  assign py = {1'b0, paddle_y};

  // Ball span [v, v+BALL_SIZE) against paddle span [y, y+PADDLE_H)
  assign overlap = ((bv + BS12) > py) && (bv < (py + PH12));

`ifdef PADDLE_ZONE_ANGLE_EN
  localparam logic [11:0]        HALF12 = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] T1     = 12'(PADDLE_H * 1 / 5);
  localparam logic signed [11:0] T2     = 12'(PADDLE_H * 2 / 5);
  localparam logic signed [11:0] T3     = 12'(PADDLE_H * 3 / 5);
  localparam logic signed [11:0] T4     = 12'(PADDLE_H * 4 / 5);
  localparam logic signed [11:0] PHS    = 12'(PADDLE_H);

  logic signed [11:0] offset;

  // Ball centre relative to the paddle top, wrapped into 12-bit two's complement
  assign offset = $signed(bv + HALF12 - py);

  // Fifths of the paddle height, clamped at both ends
  always_comb begin
    zone = 3'd0;
    if (offset[11])          zone = 3'd0;
    else if (offset >= PHS)  zone = 3'd4;
    else if (offset >= T4)   zone = 3'd4;
    else if (offset >= T3)   zone = 3'd3;
    else if (offset >= T2)   zone = 3'd2;
    else if (offset >= T1)   zone = 3'd1;
  end
`endif

endmodule

// File: rtl/pong_ball_referee.sv
// rtl/pong_ball_referee.sv - Pong referee: wall/paddle/miss checks, scoring, serve/pause/game-over FSM (option: PADDLE_ZONE_ANGLE_EN)
module pong_ball_referee #(
  parameter int unsigned BALL_SIZE      = 10,
  parameter int unsigned PADDLE_H       = 80,
  parameter int unsigned PADDLE_W       = 10,
  parameter int unsigned LEFT_PADDLE_X  = 20,
  parameter int unsigned RIGHT_PADDLE_X = 770,
  parameter int unsigned FIELD_TOP      = 10,
  parameter int unsigned FIELD_BOTTOM   = 590,
  parameter int unsigned FIELD_RIGHT    = 800,
  parameter int unsigned PAUSE_TICKS    = 60,
  parameter int unsigned WIN_SCORE      = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       move_tick,
  pong_ball_referee_if.master        bus,
  output logic [3:0]                 score_left,
  output logic [3:0]                 score_right,
  output logic                       game_over
);

  import pong_pkg::*;

  localparam logic [11:0] BS12    = 12'(BALL_SIZE);
  localparam logic [11:0] PW12    = 12'(PADDLE_W);
  localparam logic [11:0] LX12    = 12'(LEFT_PADDLE_X);
  localparam logic [11:0] RX12    = 12'(RIGHT_PADDLE_X);
  localparam logic [11:0] FT12    = 12'(FIELD_TOP);
  localparam logic [11:0] FB12    = 12'(FIELD_BOTTOM);
  localparam logic [11:0] FR12    = 12'(FIELD_RIGHT);
  localparam logic [11:0] STEP12  = 12'(STEP);
  localparam logic [15:0] PAUSE16 = 16'(PAUSE_TICKS);
  localparam logic [3:0]  WIN4    = 4'(WIN_SCORE);

  state_t      state_q, state_n;
  logic [3:0]  dir_q, dir_n;
  logic        stand_q, stand_n;
  logic        rts_q, rts_n;
  logic        check_q, check_n;
  logic [3:0]  score_l_q, score_l_n;
  logic [3:0]  score_r_q, score_r_n;
  logic        over_q, over_n;
  logic        serve_right_q, serve_right_n;
  logic        alt_q, alt_n;
  logic [15:0] pause_q, pause_n;

  logic [11:0] bh;
  logic [11:0] bv;
  logic        ov_left, ov_right;
  logic        moving_right;
  logic        hit_left, hit_right;
  logic        point_to_right, point_to_left;
  logic [3:0]  paddle_dir;
  logic [3:0]  checked_dir;

  assign bh = {1'b0, bus.ball_position_horizontal};
  assign bv = {1'b0, bus.ball_position_vertical};

`ifdef PADDLE_ZONE_ANGLE_EN
  logic [2:0] zone_left, zone_right;

  // Upper part of the paddle sends the ball steeply up, lower part steeply down
  function automatic logic [3:0] right_zone_dir(input logic [2:0] z);
    return DIR_L_UP45 - {1'b0, z};
  endfunction

  function automatic logic [3:0] left_zone_dir(input logic [2:0] z);
    return DIR_R_UP45 + {1'b0, z};
  endfunction
`endif

  paddle_zone #(
    .BALL_SIZE (BALL_SIZE),
    .PADDLE_H  (PADDLE_H)
  ) u_zone_left (
    .ball_v   (bus.ball_position_vertical),
    .paddle_y (bus.paddle_left_vertical),
`ifdef PADDLE_ZONE_ANGLE_EN
    .zone     (zone_left),
`endif
    .overlap  (ov_left)
  );

  paddle_zone #(
    .BALL_SIZE (BALL_SIZE),
    .PADDLE_H  (PADDLE_H)
  ) u_zone_right (
    .ball_v   (bus.ball_position_vertical),
    .paddle_y (bus.paddle_right_vertical),
`ifdef PADDLE_ZONE_ANGLE_EN
    .zone     (zone_right),
`endif
    .overlap  (ov_right)
  );

  assign moving_right   = is_right(dir_q);
  assign point_to_right = (bh <= STEP12);
  assign point_to_left  = ((bh + BS12) >= (FR12 - STEP12));
  assign hit_right = moving_right && ov_right &&
                     ((bh + BS12) >= RX12) && (bh <= (RX12 + PW12));
  assign hit_left  = !moving_right && ov_left &&
                     ((bh + BS12) >= LX12) && (bh <= (LX12 + PW12));

  // Direction after paddle reflection, then the wall bounce applied on top of it
  always_comb begin
    paddle_dir = dir_q;
`ifdef PADDLE_ZONE_ANGLE_EN
    if (hit_right)     paddle_dir = right_zone_dir(zone_right);
    else if (hit_left) paddle_dir = left_zone_dir(zone_left);
`else
    if (hit_right || hit_left) paddle_dir = paddle_mirror(dir_q);
`endif
    checked_dir = paddle_dir;
    if ((bv <= FT12) && is_up(paddle_dir))
      checked_dir = wall_mirror(paddle_dir);
    else if (((bv + BS12) >= FB12) && is_down(paddle_dir))
      checked_dir = wall_mirror(paddle_dir);
  end

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_n       = state_q;
    dir_n         = dir_q;
    stand_n       = 1'b1;
    check_n       = 1'b0;
    score_l_n     = score_l_q;
    score_r_n     = score_r_q;
    serve_right_n = serve_right_q;
    alt_n         = alt_q;
    pause_n       = pause_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_n = S_SERVE;
      end
      S_SERVE: begin
        state_n = S_PLAY;
      end
      S_PLAY: begin
        if (check_q) begin
          if (point_to_right) begin
            score_r_n     = score_r_q + 4'd1;
            serve_right_n = 1'b0;
            pause_n       = PAUSE16;
            state_n       = S_POINT;
          end else if (point_to_left) begin
            score_l_n     = score_l_q + 4'd1;
            serve_right_n = 1'b1;
            pause_n       = PAUSE16;
            state_n       = S_POINT;
          end else begin
            dir_n = checked_dir;
          end
        end else if (!stand_q) begin
          // Ball moves at the end of this cycle; next cycle sees the new position
          check_n = 1'b1;
        end else if (move_tick) begin
          stand_n = 1'b0;
        end
      end
      S_POINT: begin
        if ((pause_q == 16'd0) || (move_tick && (pause_q == 16'd1))) begin
          pause_n = 16'd0;
          state_n = ((score_l_q == WIN4) || (score_r_q == WIN4)) ? S_OVER : S_SERVE;
        end else if (move_tick) begin
          pause_n = pause_q - 16'd1;
        end
      end
      S_OVER: begin
        if (start) begin
          score_l_n = 4'd0;
          score_r_n = 4'd0;
          state_n   = S_SERVE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Entering a serve loads the launch angle and flips up/down for next time
    if ((state_n == S_SERVE) && (state_q != S_SERVE)) begin
      dir_n = serve_dir(serve_right_q, alt_q);
      alt_n = ~alt_q;
    end

    rts_n  = (state_n != S_PLAY);
    over_n = (state_n == S_OVER);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      dir_q         <= DIR_R_FRONT;
      stand_q       <= 1'b1;
      rts_q         <= 1'b1;
      check_q       <= 1'b0;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      over_q        <= 1'b0;
      serve_right_q <= 1'b1;
      alt_q         <= 1'b0;
      pause_q       <= 16'd0;
    end else begin
      state_q       <= state_n;
      dir_q         <= dir_n;
      stand_q       <= stand_n;
      rts_q         <= rts_n;
      check_q       <= check_n;
      score_l_q     <= score_l_n;
      score_r_q     <= score_r_n;
      over_q        <= over_n;
      serve_right_q <= serve_right_n;
      alt_q         <= alt_n;
      pause_q       <= pause_n;
    end
  end

  assign bus.direction      = dir_q;
  assign bus.stand          = stand_q;
  assign bus.reset_to_start = rts_q;
  assign score_left         = score_l_q;
  assign score_right        = score_r_q;
  assign game_over          = over_q;

endmodule

// File: tb/tb_pong_ball_referee.sv
// tb/tb_pong_ball_referee.sv - directed scoreboard bench for pong_ball_referee (expectations follow PADDLE_ZONE_ANGLE_EN)
module tb_pong_ball_referee;

  import pong_pkg::*;

`ifdef PADDLE_ZONE_ANGLE_EN
  localparam bit ZONE_EN = 1'b1;
`else
  localparam bit ZONE_EN = 1'b0;
`endif
  localparam int PAUSE = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       move_tick;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;

  pong_ball_referee_if bus();

  pong_ball_referee dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .move_tick   (move_tick),
    .bus         (bus),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    exp_q[$];
  string tag_q[$];
  int    exp_dir = 3;
  bit    alt_m = 1'b0;
  bit    serve_right_m = 1'b1;
  int    sl_m = 0;
  int    sr_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected a queued entry", obs);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_ball(input int h, input int v);
    bus.ball_position_horizontal = 11'(h);
    bus.ball_position_vertical   = 11'(v);
  endtask

  function automatic int serve_code(input bit right, input bit alt);
    if (right) return alt ? 4 : 2;
    return alt ? 7 : 9;
  endfunction

  // One move: stand low for exactly one cycle, new direction two cycles later
  task automatic do_step(input string tag, input int exp_d);
    sb_push(tag, exp_d);
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    chk({tag, "_stand"}, bus.stand, 0);
    cyc();
    cyc();
    sb_check(bus.direction);
    exp_dir = exp_d;
  endtask

  task automatic do_miss(input int h);
    set_ball(h, 325);
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    cyc();
    cyc();
    if (h <= 5) begin
      sr_m++;
      serve_right_m = 1'b0;
    end else begin
      sl_m++;
      serve_right_m = 1'b1;
    end
    sb_push("miss_score_left", sl_m);
    sb_push("miss_score_right", sr_m);
    sb_check(score_left);
    sb_check(score_right);
    chk("miss_stand", bus.stand, 1);
    set_ball(BALL_START_X, BALL_START_Y);
  endtask

  task automatic do_pause(input bit expect_over);
    for (int i = 0; i < PAUSE - 1; i++) begin
      move_tick = 1'b1;
      cyc();
      move_tick = 1'b0;
      chk("pause_stand", bus.stand, 1);
      cyc();
    end
    chk("pause_dir_hold", bus.direction, exp_dir);
    chk("pause_not_over", game_over, 0);
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    if (expect_over) begin
      chk("over_flag", game_over, 1);
      chk("over_stand", bus.stand, 1);
      cyc();
    end else begin
      exp_dir = serve_code(serve_right_m, alt_m);
      alt_m = ~alt_m;
      sb_push("serve_dir", exp_dir);
      sb_check(bus.direction);
      chk("serve_rts", bus.reset_to_start, 1);
      cyc();
      chk("play_rts", bus.reset_to_start, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    move_tick = 1'b0;
    set_ball(BALL_START_X, BALL_START_Y);
    bus.paddle_left_vertical  = 11'd300;
    bus.paddle_right_vertical = 11'd300;
    #12;
    chk("rst_dir", bus.direction, 3);
    chk("rst_stand", bus.stand, 1);
    chk("rst_rts", bus.reset_to_start, 1);
    chk("rst_score_left", score_left, 0);
    chk("rst_score_right", score_right, 0);
    chk("rst_game_over", game_over, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    cyc();
    chk("idle_rts", bus.reset_to_start, 1);
    chk("idle_stand", bus.stand, 1);

    // First serve goes right, upward
    start = 1'b1;
    exp_dir = serve_code(serve_right_m, alt_m);
    alt_m = ~alt_m;
    sb_push("serve1_dir", exp_dir);
    cyc();
    start = 1'b0;
    sb_check(bus.direction);
    chk("serve1_rts", bus.reset_to_start, 1);
    cyc();
    chk("play1_rts", bus.reset_to_start, 0);
    chk("play1_stand", bus.stand, 1);

    // move_tick held through step and check cycles: only the first is taken
    sb_push("drop_dir_hold", exp_dir);
    move_tick = 1'b1;
    cyc();
    chk("drop_stand0", bus.stand, 0);
    cyc();
    chk("drop_stand1", bus.stand, 1);
    cyc();
    move_tick = 1'b0;
    chk("drop_stand2", bus.stand, 1);
    sb_check(bus.direction);
    cyc();
    chk("drop_stand3", bus.stand, 1);

    // Walls
    set_ball(400, 8);
    do_step("top_wall", 4);
    set_ball(400, 579);
    do_step("bottom_near", 4);
    set_ball(400, 582);
    do_step("bottom_wall", 2);

    // Right paddle centre zone
    set_ball(762, 335);
    do_step("right_paddle_zone2", ZONE_EN ? 8 : 9);

    // start is ignored while playing
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("play_start_rts", bus.reset_to_start, 0);
    chk("play_start_dir", bus.direction, exp_dir);
    chk("play_start_score", score_left, 0);

    // Left paddle top zone together with the top wall
    bus.paddle_left_vertical = 11'd10;
    set_ball(25, 8);
    do_step("left_paddle_top_wall", ZONE_EN ? 5 : 4);
    bus.paddle_left_vertical = 11'd300;

    // Paddle vertical edge: half-open range, then clamp to the bottom zone
    set_ball(762, 380);
    do_step("right_paddle_below", exp_dir);
    set_ball(762, 379);
    do_step("right_paddle_zone4", ZONE_EN ? 6 : 7);

    // Right-side miss, pause, serve right (second serve is downward)
    do_miss(786);
    do_pause(1'b0);

    // Left edge: one pixel inside holds, on the margin is a miss
    set_ball(6, 325);
    do_step("left_edge_inside", exp_dir);
    do_miss(5);
    do_pause(1'b0);

    set_ball(784, 325);
    do_step("right_edge_inside", exp_dir);

    // Run the left player up to the winning score
    for (int p = 0; p < 7; p++) begin
      do_miss(785);
      do_pause(1'b0);
    end
    do_miss(785);
    do_pause(1'b1);
    chk("over_score_left", score_left, 9);
    chk("over_stand_hold", bus.stand, 1);

    // Restart from game over
    start = 1'b1;
    exp_dir = serve_code(serve_right_m, alt_m);
    alt_m = ~alt_m;
    sl_m = 0;
    sr_m = 0;
    sb_push("restart_dir", exp_dir);
    cyc();
    start = 1'b0;
    sb_check(bus.direction);
    chk("restart_score_left", score_left, 0);
    chk("restart_score_right", score_right, 0);
    chk("restart_game_over", game_over, 0);
    chk("restart_rts", bus.reset_to_start, 1);
    cyc();

    do_miss(790);
    do_pause(1'b0);

    // Asynchronous reset between edges during a step
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    chk("pre_reset_stand", bus.stand, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_dir", bus.direction, 3);
    chk("async_stand", bus.stand, 1);
    chk("async_rts", bus.reset_to_start, 1);
    chk("async_score_left", score_left, 0);
    chk("async_score_right", score_right, 0);
    chk("async_game_over", game_over, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
